// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between NUM_REQ requesters and the register-file arbiter.
// master: requester side (req/lock/addr/data/stall); slave: arbiter side.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ-1:0]   lock_i;
  logic [NUM_REQ*3-1:0] addr_i;
  logic [NUM_REQ*8-1:0] data_i;
  logic                 stall_i;
  logic [NUM_REQ-1:0]   gnt_o;
  logic [2:0]           wr_addr_o;
  logic                 wr_en_o;
  logic [7:0]           wr_data_o;
  logic [OWN_W-1:0]     owner_o;
  logic                 busy_o;

  modport master (
    output req_i, lock_i, addr_i, data_i, stall_i,
    input  gnt_o, wr_addr_o, wr_en_o, wr_data_o,
    input  owner_o, busy_o
  );

  modport slave (
    input  req_i, lock_i, addr_i, data_i, stall_i,
    output gnt_o, wr_addr_o, wr_en_o, wr_data_o,
    output owner_o, busy_o
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter with locked bursts for the 8x8 register file.
// Ports: clk_i, rst_ni (async low), bus (slave). Option: REGFILE_ARB_PRIO_EN.
module regfile_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  localparam int OWN_W    = $clog2(NUM_REQ)
) (
  input logic clk_i,
  input logic rst_ni,
  regfile_wr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam bit BURST_EN = (MAX_BURST > 1);
  localparam logic [3:0] LAST = 4'(MAX_BURST);
`ifdef REGFILE_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  state_e           state_q;
  logic [OWN_W-1:0] rr_ptr_q;
  logic [OWN_W-1:0] owner_q;
  logic [3:0]       beat_q;
  logic             wr_en_q;
  logic [2:0]       wr_addr_q;
  logic [7:0]       wr_data_q;
  logic             busy_q;

  logic [OWN_W-1:0] pick;
  logic             found;
  logic [OWN_W-1:0] sel;
  logic             xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [OWN_W-1:0] rr_nxt;
  logic             last_beat;

  // Rotating scan starting at rr_ptr.
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_i[idx]) begin
        found = 1'b1;
        pick  = OWN_W'(idx);
      end
    end
`ifdef REGFILE_ARB_PRIO_EN
    if (bus.req_i[0]) begin
      found = 1'b1;
      pick  = '0;
    end
`endif
  end

  // Inside a burst only the owner may be granted.
  always_comb begin
    sel  = (state_q == BURST) ? owner_q : pick;
    xfer = 1'b0;
    if (rst_ni && !bus.stall_i) begin
      unique case (state_q)
        IDLE:  xfer = found;
        BURST: xfer = bus.req_i[owner_q];
        default: xfer = 1'b0;
      endcase
    end
    gnt      = '0;
    gnt[sel] = xfer;
  end

  assign rr_nxt = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
  assign last_beat = (beat_q + 4'd1) == LAST;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      beat_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q <= xfer;
      if (xfer) begin
        wr_addr_q <= bus.addr_i[int'(sel)*3 +: 3];
        wr_data_q <= bus.data_i[int'(sel)*8 +: 8];
      end
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            owner_q <= sel;
            // A priority grant to requester 0 leaves the rotation alone.
            if (!(PRIO && sel == '0)) rr_ptr_q <= rr_nxt;
            if (bus.lock_i[sel] && BURST_EN) begin
              state_q <= BURST;
              beat_q  <= 4'd1;
              busy_q  <= 1'b1;
            end
          end
        end
        BURST: begin
          if (!bus.stall_i) begin
            if (!xfer || !bus.lock_i[sel] || last_beat) begin
              state_q <= IDLE;
              beat_q  <= '0;
              busy_q  <= 1'b0;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o     = gnt;
  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
  assign bus.owner_o   = owner_q;
  assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (NUM_REQ=4, MAX_BURST=4).
// Ports: none; drives the arbiter through its interface.
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst_ni;
  int   checks;
  int   errors;

  regfile_wr_arbiter_if #(.NUM_REQ(4)) bus ();

  regfile_wr_arbiter #(
    .NUM_REQ  (4),
    .MAX_BURST(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    bus.req_i   = 4'b1111;
    bus.lock_i  = 4'b0000;
    bus.stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.addr_i[k*3 +: 3] = 3'(k);
      bus.data_i[k*8 +: 8] = 8'h10 + 8'(k);
    end
    #1;
    chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("rst_wr_en", 32'(bus.wr_en_o), 32'h0);
    chk("rst_wr_addr", 32'(bus.wr_addr_o), 32'h0);
    chk("rst_wr_data", 32'(bus.wr_data_o), 32'h0);
    chk("rst_owner", 32'(bus.owner_o), 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);

    cyc();
    rst_ni = 1'b1;
    #1;
    chk("rel_gnt", 32'(bus.gnt_o), 32'h1);

    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_gnt", 32'(bus.gnt_o), 32'h1 << (i % 4));
      cyc();
      chk("rr_wr_en", 32'(bus.wr_en_o), 32'h1);
      chk("rr_wr_addr", 32'(bus.wr_addr_o), 32'(i % 4));
      chk("rr_wr_data", 32'(bus.wr_data_o), 32'h10 + 32'(i % 4));
      chk("rr_owner", 32'(bus.owner_o), 32'(i % 4));
    end

    // Burst cap: requester 2 locked, requester 1 joins after beat 1.
    bus.req_i  = 4'b0100;
    bus.lock_i = 4'b0100;
    #1;
    chk("bst_gnt", 32'(bus.gnt_o), 32'h4);
    for (int b = 0; b < 4; b++) begin
      cyc();
      chk("bst_wr_en", 32'(bus.wr_en_o), 32'h1);
      chk("bst_wr_addr", 32'(bus.wr_addr_o), 32'h2);
      chk("bst_busy", 32'(bus.busy_o), (b < 3) ? 32'h1 : 32'h0);
      if (b == 0) bus.req_i = 4'b0110;
      if (b < 3) begin
        #1;
        chk("bst_gnt", 32'(bus.gnt_o), 32'h4);
      end
    end
    #1;
    chk("bst_next_gnt", 32'(bus.gnt_o), 32'h2);

    // Stall at beat 2 of a burst by requester 1.
    bus.req_i  = 4'b0010;
    bus.lock_i = 4'b0010;
    #1;
    chk("stl_gnt1", 32'(bus.gnt_o), 32'h2);
    cyc();
    chk("stl_busy1", 32'(bus.busy_o), 32'h1);
    chk("stl_owner", 32'(bus.owner_o), 32'h1);
    #1;
    chk("stl_gnt2", 32'(bus.gnt_o), 32'h2);
    cyc();
    bus.stall_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stl_gnt0", 32'(bus.gnt_o), 32'h0);
      cyc();
      chk("stl_wr_en", 32'(bus.wr_en_o), 32'h0);
      chk("stl_busy", 32'(bus.busy_o), 32'h1);
    end
    bus.stall_i = 1'b0;
    #1;
    chk("stl_gnt3", 32'(bus.gnt_o), 32'h2);
    cyc();
    chk("stl_wr_en3", 32'(bus.wr_en_o), 32'h1);
    chk("stl_busy3", 32'(bus.busy_o), 32'h1);
    #1;
    chk("stl_gnt4", 32'(bus.gnt_o), 32'h2);
    cyc();
    chk("stl_wr_en4", 32'(bus.wr_en_o), 32'h1);
    chk("stl_busy4", 32'(bus.busy_o), 32'h0);
    bus.req_i = 4'b0000;
    #1;
    chk("idle_gnt", 32'(bus.gnt_o), 32'h0);
    cyc();
    chk("idle_wr_en", 32'(bus.wr_en_o), 32'h0);

    // Early release: owner 3 drops req after beat 1.
    bus.req_i  = 4'b1000;
    bus.lock_i = 4'b1000;
    #1;
    chk("er_gnt", 32'(bus.gnt_o), 32'h8);
    cyc();
    chk("er_busy", 32'(bus.busy_o), 32'h1);
    chk("er_owner", 32'(bus.owner_o), 32'h3);
    chk("er_wr_addr", 32'(bus.wr_addr_o), 32'h3);
    bus.req_i  = 4'b0001;
    bus.lock_i = 4'b0000;
    #1;
    chk("er_gnt0", 32'(bus.gnt_o), 32'h0);
    cyc();
    chk("er_busy0", 32'(bus.busy_o), 32'h0);
    chk("er_wr_en0", 32'(bus.wr_en_o), 32'h0);
    #1;
    chk("er_next_gnt", 32'(bus.gnt_o), 32'h1);
    cyc();
    chk("er_next_wr", 32'(bus.wr_en_o), 32'h1);
    chk("er_next_data", 32'(bus.wr_data_o), 32'h10);
    chk("er_next_owner", 32'(bus.owner_o), 32'h0);

    // Async reset during beat 2 of a burst by requester 2.
    bus.req_i  = 4'b0100;
    bus.lock_i = 4'b0100;
    #1;
    chk("ar_gnt1", 32'(bus.gnt_o), 32'h4);
    cyc();
    chk("ar_busy1", 32'(bus.busy_o), 32'h1);
    #1;
    chk("ar_gnt2", 32'(bus.gnt_o), 32'h4);
    cyc();
    chk("ar_wr_en2", 32'(bus.wr_en_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_wr_en", 32'(bus.wr_en_o), 32'h0);
    chk("ar_busy", 32'(bus.busy_o), 32'h0);
    chk("ar_gnt", 32'(bus.gnt_o), 32'h0);
    chk("ar_owner", 32'(bus.owner_o), 32'h0);
    cyc();
    rst_ni = 1'b1;
    bus.req_i  = 4'b1111;
    bus.lock_i = 4'b0000;
    #1;
    chk("ar_rel_gnt", 32'(bus.gnt_o), 32'h1);
    cyc();
    chk("ar_rel_wr_en", 32'(bus.wr_en_o), 32'h1);
    chk("ar_rel_addr", 32'(bus.wr_addr_o), 32'h0);
    chk("ar_rel_busy", 32'(bus.busy_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Write-port arbiter and sequencer for the 8-entry x 8-bit register file.
- Shares the single write port among NUM_REQ requesters using round-robin arbitration, with optional locked bursts.
- Drives a registered write address, enable and data. These feed the 3-to-8 write-select decoder (address -> A_i, enable -> EN_i) and the register data inputs.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- MAX_BURST, 4: maximum consecutive writes per locked burst; legal range 1..15. A value of 1 disables bursts.
- OWN_W, $clog2(NUM_REQ): width of the owner index; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester write request.
- lock_i  in  NUM_REQ  per-requester burst lock; sampled only on a transfer.
- addr_i  in  NUM_REQ*3  packed write addresses; requester k uses bits [3k+2:3k].
- data_i  in  NUM_REQ*8  packed write data; requester k uses bits [8k+7:8k].
- stall_i  in  1  register file busy; blocks all grants in the current cycle.
- gnt_o  out  NUM_REQ  one-hot-or-zero grant; combinational.
- wr_addr_o  out  3  registered write address, to the decoder A_i.
- wr_en_o  out  1  registered write enable, to the decoder EN_i.
- wr_data_o  out  8  registered write data.
- owner_o  out  OWN_W  index of the most recently granted requester.
- busy_o  out  1  high while in BURST.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: gnt_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, owner_o=0, busy_o=0. Internal state: FSM=IDLE, rr_ptr=0, beat_cnt=0.
- Reset mid-burst: the burst is abandoned immediately. wr_en_o drops asynchronously. No further write is issued after release.
- Transfer: occurs in any cycle where req_i[k] & gnt_o[k].
- gnt_o has at most one bit set. gnt_o is forced to 0 when stall_i=1 or rst_ni=0.
- FSM, IDLE state:
  - Scan req_i from rr_ptr upward, modulo NUM_REQ; grant the first requester k found.
  - On transfer: rr_ptr<=(k+1) mod NUM_REQ, owner_o<=k.
  - If lock_i[k]=1 and MAX_BURST>1, go to BURST with beat_cnt<=1. Otherwise stay in IDLE.
- FSM, BURST state:
  - Only requester owner_o can be granted; all other gnt_o bits are 0.
  - Each transfer increments beat_cnt.
  - Return to IDLE on a transfer with lock_i[owner]=0.
  - Return to IDLE on a transfer where beat_cnt+1==MAX_BURST; that transfer is the final beat.
  - Return to IDLE in any non-stalled cycle with req_i[owner]=0. No grant is issued in that cycle.
  - While stall_i=1: hold state and beat_cnt.
  - rr_ptr is not modified inside BURST. It already points past the owner.
- Output stage (latency 1 cycle from transfer):
  - On transfer: wr_en_o<=1, wr_addr_o<=addr_i[k], wr_data_o<=data_i[k].
  - Otherwise: wr_en_o<=0; wr_addr_o and wr_data_o hold their last values.
  - Back-to-back transfers produce wr_en_o high on consecutive cycles. Throughput is 1 write per cycle.
- busy_o: registered, equal to (FSM==BURST).
- Requester rules:
  - A requester keeps req_i, addr_i and data_i stable until granted.
  - A requester may deassert req_i only after a transfer.
  - The arbiter does not check address collisions between requesters.
- No starvation: in IDLE, any continuously requesting agent is granted within NUM_REQ transfers. In addition, each burst lasts at most MAX_BURST beats.

Optional Feature:
- Macro: REGFILE_ARB_PRIO_EN.
- When defined: requester 0 has fixed highest priority in IDLE. If req_i[0]=1, it is granted regardless of rr_ptr, and rr_ptr is not updated on that grant. The remaining requesters keep round-robin among themselves. Requester 0 does not preempt an active burst.
- When undefined: pure round-robin as above.

Test Plan:
- Reset: hold rst_ni=0 with req_i=4'b1111 -> gnt_o=0, wr_en_o=0, all outputs 0. Release -> first grant is gnt_o=4'b0001 and owner_o=0.
- Round-robin: req_i=4'b1111, lock_i=0, addr_i[k]=k, data_i[k]=8'h10+k, held for 8 cycles -> grants 0,1,2,3,0,1,2,3. wr_en_o high from cycle 2 onward; wr_addr_o 0,1,2,3,... lagging the grant by 1 cycle.
- Burst cap: requester 2 with lock_i[2]=1, requester 1 also requesting, MAX_BURST=4 -> exactly 4 consecutive grants to 2 with busy_o=1, then grant to requester 3-or-wrap per rr_ptr. Requester 1 is served within NUM_REQ further transfers.
- Stall: drive stall_i=1 for 3 cycles mid-burst at beat 2 -> gnt_o=0 and wr_en_o=0 for those cycles; beat_cnt is held. The burst completes with 2 more beats after stall_i falls.
- Early release: burst owner drops req_i after beat 1 -> FSM returns to IDLE, busy_o falls next cycle, and the next requester is granted in the following cycle.
- Async reset mid-burst: assert rst_ni=0 between clock edges during beat 2 -> wr_en_o and busy_o fall immediately. After release, rr_ptr=0.
